// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch stage.
package riscv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_FAULT
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC select (sequential vs redirect) and target alignment check.
module pc_next_logic
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_target,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_misaligned
);

  logic [XLEN-1:0] w_pc_plus4;

  // Wraps modulo 2^XLEN; the top word falls through to address zero.
  assign w_pc_plus4   = i_pc + XLEN'(4);
  assign o_next_pc    = i_redirect_valid ? i_redirect_target : w_pc_plus4;
  assign o_misaligned = |o_next_pc[1:0];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Multi-cycle fetch stage: owns the PC, fetches over valid/ready, holds the word for decode.
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4,
  output logic [24:0]     inm_gen,
  output logic            fetch_fault
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic            r_instr_valid;
  logic            r_req_valid;
  logic            r_fault;

  logic [XLEN-1:0] w_next_pc;
  logic            w_misaligned;

  pc_next_logic #(
    .XLEN (XLEN)
  ) u_pc_next_logic (
    .i_pc              (r_pc),
    .i_redirect_valid  (redirect_valid),
    .i_redirect_target (redirect_target),
    .o_next_pc         (w_next_pc),
    .o_misaligned      (w_misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= INSTR_NOP;
      r_instr_pc    <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_req_valid   <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state     <= S_REQ;
          r_req_valid <= 1'b1;
        end
        S_REQ: begin
          if (imem_req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            r_instr       <= imem_rsp_data;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_state       <= S_VALID;
          end
        end
        S_VALID: begin
          // Redirects are only honoured on the consuming cycle.
          if (!stall) begin
            r_instr_valid <= 1'b0;
            if (w_misaligned) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_pc        <= w_next_pc;
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end
          end
        end
        S_FAULT: begin
          r_fault       <= 1'b1;
          r_instr_valid <= 1'b0;
          r_req_valid   <= 1'b0;
        end
        default: begin
          r_state       <= S_IDLE;
          r_instr_valid <= 1'b0;
          r_req_valid   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_addr      = r_pc;
  assign instr_valid    = r_instr_valid;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign instr_pc_plus4 = r_instr_pc + XLEN'(4);
  assign inm_gen        = r_instr[31:7];
  assign fetch_fault    = r_fault;

endmodule
